// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: state encoding,
// common keyboard command bytes, frame payload and microsecond-to-cycle helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  localparam int unsigned BITCNT_W = 4;
  localparam logic [BITCNT_W-1:0] BIT_LAST_DATA = 4'd7;
  localparam logic [BITCNT_W-1:0] BIT_PARITY    = 4'd8;
  localparam logic [BITCNT_W-1:0] BIT_MAX       = 4'hF;

  // Byte being shifted out plus its precomputed odd parity bit.
  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } ps2_frame_t;

  function automatic int unsigned us_to_cyc(input int unsigned freq_hz,
                                            input int unsigned us);
    return (freq_hz / 32'd1_000_000) * us;
  endfunction

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// Two-flop synchronizer for one raw PS/2 line with a registered falling-edge flag
// that is aligned with the synchronized level.
module ps2_host_tx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_fall;

  // Idle level of a pulled-up PS/2 line is high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_fall <= r_sync & ~r_meta;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-clock frame, ACK check.
// Optional device watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_US  = 15000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic       i_kbclk,
  input  logic       i_kbdata,
  output logic       o_kbclk_oe,
  output logic       o_kbdata_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int unsigned INHIBIT_CYC = us_to_cyc(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned TIMEOUT_CYC = us_to_cyc(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int unsigned CNT_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYC - 32'd1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 32'd1);

  ps2_tx_state_e         r_state;
  ps2_tx_state_e         w_state_nxt;
  ps2_frame_t            r_frame;
  ps2_frame_t            w_frame_nxt;
  logic [BITCNT_W-1:0]   r_bitcnt;
  logic [BITCNT_W-1:0]   w_bitcnt_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_kbclk_oe;
  logic                  w_kbclk_oe_nxt;
  logic                  r_kbdata_oe;
  logic                  w_kbdata_oe_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic                  r_tx_ready;
  logic                  r_busy;

  logic w_clk_lvl;
  logic w_clk_fall;
  logic w_data_lvl;
  logic w_data_fall;
  logic w_unused;

  ps2_host_tx_sync u_sync_clk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_line  (i_kbclk),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  ps2_host_tx_sync u_sync_data (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_line  (i_kbdata),
    .o_level (w_data_lvl),
    .o_fall  (w_data_fall)
  );

  // The transmitter only needs the data level; its edge flag has no consumer here.
  assign w_unused = w_data_fall;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_frame     <= '0;
      r_bitcnt    <= '0;
      r_cnt       <= '0;
      r_kbclk_oe  <= 1'b0;
      r_kbdata_oe <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_tx_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame     <= w_frame_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_cnt       <= w_cnt_nxt;
      r_kbclk_oe  <= w_kbclk_oe_nxt;
      r_kbdata_oe <= w_kbdata_oe_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_tx_ready  <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_nxt     = r_frame;
    w_bitcnt_nxt    = r_bitcnt;
    w_cnt_nxt       = r_cnt;
    w_kbclk_oe_nxt  = r_kbclk_oe;
    w_kbdata_oe_nxt = r_kbdata_oe;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_kbclk_oe_nxt  = 1'b0;
        w_kbdata_oe_nxt = 1'b0;
        if (i_tx_valid && r_tx_ready) begin
          w_frame_nxt.data = i_tx_data;
          w_frame_nxt.par  = odd_parity(i_tx_data);
          w_bitcnt_nxt     = '0;
          w_cnt_nxt        = INHIBIT_LOAD;
          w_kbclk_oe_nxt   = 1'b1;
          w_kbdata_oe_nxt  = (INHIBIT_CYC <= 32'd1);
          w_state_nxt      = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        w_kbclk_oe_nxt = 1'b1;
        if (r_cnt == '0) begin
          // Release clock while keeping data low: this is the start bit / request-to-send.
          w_kbclk_oe_nxt  = 1'b0;
          w_kbdata_oe_nxt = 1'b1;
          w_cnt_nxt       = TIMEOUT_LOAD;
          w_state_nxt     = ST_RTS;
        end else begin
          w_cnt_nxt       = r_cnt - CNT_W'(1);
          w_kbdata_oe_nxt = (r_cnt == CNT_W'(1));
        end
      end

      ST_RTS: begin
        w_kbclk_oe_nxt  = 1'b0;
        w_kbdata_oe_nxt = 1'b1;
        w_bitcnt_nxt    = '0;
        w_state_nxt     = ST_SEND;
      end

      ST_SEND: begin
        w_kbclk_oe_nxt = 1'b0;
        if (w_clk_fall) begin
          if (r_bitcnt <= BIT_LAST_DATA) begin
            w_kbdata_oe_nxt  = ~r_frame.data[0];
            w_frame_nxt.data = {1'b0, r_frame.data[7:1]};
          end else if (r_bitcnt == BIT_PARITY) begin
            w_kbdata_oe_nxt = ~r_frame.par;
          end else begin
            w_kbdata_oe_nxt = 1'b0;
            w_state_nxt     = ST_ACK;
          end
          if (r_bitcnt != BIT_MAX) begin
            w_bitcnt_nxt = r_bitcnt + BITCNT_W'(1);
          end
        end
      end

      ST_ACK: begin
        w_kbclk_oe_nxt  = 1'b0;
        w_kbdata_oe_nxt = 1'b0;
        if (w_clk_fall) begin
          w_done_nxt  = ~w_data_lvl;
          w_err_nxt   = w_data_lvl;
          w_state_nxt = ST_WAIT_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        w_kbclk_oe_nxt  = 1'b0;
        w_kbdata_oe_nxt = 1'b0;
        if (w_clk_lvl && w_data_lvl) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_kbclk_oe_nxt  = 1'b0;
        w_kbdata_oe_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog overrides any clock fall seen on the expiry cycle.
    if (r_state inside {ST_RTS, ST_SEND, ST_ACK}) begin
      if (r_cnt == '0) begin
        w_frame_nxt     = r_frame;
        w_bitcnt_nxt    = r_bitcnt;
        w_kbclk_oe_nxt  = 1'b0;
        w_kbdata_oe_nxt = 1'b0;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b1;
        w_state_nxt     = ST_WAIT_IDLE;
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end
`endif
  end

  assign o_tx_ready  = r_tx_ready;
  assign o_busy      = r_busy;
  assign o_kbclk_oe  = r_kbclk_oe;
  assign o_kbdata_oe = r_kbdata_oe;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
